// File: rtl/pwm_capture_pkg.sv
// Shared types and defaults for the PWM input capture block.
package pwm_capture_pkg;

   localparam int CNT_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_e;

   typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Register-bank side of the capture block: per-channel configuration in, measurement results out.
interface pwm_capture_if
   import pwm_capture_pkg::*;
#(
   parameter int CHANNELS = 3,
   parameter int CNT_W    = CNT_W_DEF
);

   logic [CHANNELS-1:0]            enable_i;
   logic [CHANNELS-1:0][CNT_W-1:0] prescaler_i;
   logic [CHANNELS-1:0]            clear_i;
   logic [CHANNELS-1:0][CNT_W-1:0] period_o;
   logic [CHANNELS-1:0][CNT_W-1:0] high_o;
   logic [CHANNELS-1:0]            valid_o;
   logic [CHANNELS-1:0]            overflow_o;

   modport master (
      output enable_i, prescaler_i, clear_i,
      input  period_o, high_o, valid_o, overflow_o
   );

   modport slave (
      input  enable_i, prescaler_i, clear_i,
      output period_o, high_o, valid_o, overflow_o
   );

endinterface

// File: rtl/pwm_capture_chan.sv
// One capture channel: pin synchronizer, tick prescaler, period/high counter and measurement FSM.
module pwm_capture_chan
   import pwm_capture_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             pwm_i,
   input  logic             enable_i,
   input  logic [CNT_W-1:0] prescaler_i,
   input  logic             clear_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             overflow_o
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s_d_reg;
   state_e                 state_reg, state_next;
   logic [CNT_W-1:0]       pre_reg, pre_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [CNT_W-1:0]       hi_reg, hi_next;
   logic [CNT_W-1:0]       period_reg, period_next;
   logic [CNT_W-1:0]       high_reg, high_next;
   logic                   valid_reg, valid_next;
   logic                   ovf_reg, ovf_next;

   logic             s, rise, fall, tick, cnt_max;
   logic [CNT_W-1:0] cnt_inc;

   assign s       = sync_reg[SYNC_STAGES-1];
   assign rise    = s & ~s_d_reg;
   assign fall    = ~s & s_d_reg;
   assign tick    = (pre_reg == prescaler_i);
   assign cnt_max = &cnt_reg;
   // Saturating increment so an edge coinciding with saturation still reports all-ones.
   assign cnt_inc = cnt_max ? cnt_reg : cnt_reg + CNT_W'(1);

   always_comb begin
      state_next  = state_reg;
      pre_next    = pre_reg;
      cnt_next    = cnt_reg;
      hi_next     = hi_reg;
      period_next = period_reg;
      high_next   = high_reg;
      valid_next  = 1'b0;
      ovf_next    = ovf_reg & ~clear_i;

      if (rise || tick) pre_next = '0;
      else              pre_next = pre_reg + CNT_W'(1);

      case (state_reg)
         IDLE: begin
            pre_next = '0;
            cnt_next = '0;
            if (enable_i) state_next = ARM;
         end
         ARM: begin
            if (rise) begin
               cnt_next   = CNT_W'(1);
               state_next = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               hi_next    = cnt_reg;
               state_next = LOW;
               if (tick) cnt_next = cnt_inc;
            end else if (tick) begin
               if (cnt_max) begin
                  ovf_next   = 1'b1;
                  cnt_next   = '0;
                  state_next = ARM;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         LOW: begin
            if (rise) begin
               period_next = cnt_reg;
               high_next   = hi_reg;
               valid_next  = 1'b1;
               cnt_next    = CNT_W'(1);
               state_next  = HIGH;
            end else if (tick) begin
               if (cnt_max) begin
                  ovf_next   = 1'b1;
                  cnt_next   = '0;
                  state_next = ARM;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Disabling aborts any partial measurement but leaves published results intact.
      if (!enable_i) begin
         state_next = IDLE;
         pre_next   = '0;
         cnt_next   = '0;
         valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sync_reg   <= '0;
         s_d_reg    <= 1'b0;
         state_reg  <= IDLE;
         pre_reg    <= '0;
         cnt_reg    <= '0;
         hi_reg     <= '0;
         period_reg <= '0;
         high_reg   <= '0;
         valid_reg  <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         sync_reg   <= {sync_reg[SYNC_STAGES-2:0], pwm_i};
         s_d_reg    <= s;
         state_reg  <= state_next;
         pre_reg    <= pre_next;
         cnt_reg    <= cnt_next;
         hi_reg     <= hi_next;
         period_reg <= period_next;
         high_reg   <= high_next;
         valid_reg  <= valid_next;
         ovf_reg    <= ovf_next;
      end
   end

   assign period_o   = period_reg;
   assign high_o     = high_reg;
   assign valid_o    = valid_reg;
   assign overflow_o = ovf_reg;

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM input capture: one independent capture channel per pin.
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int CHANNELS    = 3,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic [CHANNELS-1:0] pwm_i,
   pwm_capture_if.slave        cap
);

   logic [CHANNELS-1:0][CNT_W-1:0] period_w;
   logic [CHANNELS-1:0][CNT_W-1:0] high_w;
   logic [CHANNELS-1:0]            valid_w;
   logic [CHANNELS-1:0]            ovf_w;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         pwm_capture_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES)
         ) u_chan (
            .clk_i       (clk_i),
            .rstn_i      (rstn_i),
            .pwm_i       (pwm_i[gi]),
            .enable_i    (cap.enable_i[gi]),
            .prescaler_i (cap.prescaler_i[gi]),
            .clear_i     (cap.clear_i[gi]),
            .period_o    (period_w[gi]),
            .high_o      (high_w[gi]),
            .valid_o     (valid_w[gi]),
            .overflow_o  (ovf_w[gi])
         );
      end
   endgenerate

   assign cap.period_o   = period_w;
   assign cap.high_o     = high_w;
   assign cap.valid_o    = valid_w;
   assign cap.overflow_o = ovf_w;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a 3-channel 32-bit instance and a 1-channel 8-bit instance for saturation.
module tb_pwm_capture;

   logic       clk_i = 1'b0;
   logic       rstn_i;
   logic [2:0] pwm_a;
   logic [0:0] pwm_b;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      longint period;
      longint high;
   } exp_t;

   exp_t   exp_q[4][$];
   longint last_p[4];
   longint last_h[4];

   pwm_capture_if #(.CHANNELS(3), .CNT_W(32)) if_a ();
   pwm_capture_if #(.CHANNELS(1), .CNT_W(8))  if_b ();

   pwm_capture #(.CHANNELS(3), .CNT_W(32), .SYNC_STAGES(2)) dut_a (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .pwm_i  (pwm_a),
      .cap    (if_a)
   );

   pwm_capture #(.CHANNELS(1), .CNT_W(8), .SYNC_STAGES(2)) dut_b (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .pwm_i  (pwm_b),
      .cap    (if_b)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic longint model(input int p, input int presc);
      return longint'(1 + (p - 1) / (presc + 1));
   endfunction

   task automatic set_pin(input int c, input logic v);
      if (c < 3) pwm_a[c] = v;
      else       pwm_b[0] = v;
   endtask

   task automatic push_exp(input int c, input int per, input int hi, input int presc);
      exp_t e;
      e.period = model(per, presc);
      e.high   = model(hi, presc);
      exp_q[c].push_back(e);
   endtask

   // Caller is aligned to a negedge; n+1 rises give n complete periods.
   task automatic drive_wave(input int c, input int n, input int per, input int hi, input int presc);
      for (int k = 0; k <= n; k++) begin
         set_pin(c, 1'b1);
         if (k > 0) push_exp(c, per, hi, presc);
         repeat (hi) @(negedge clk_i);
         set_pin(c, 1'b0);
         if (k < n) repeat (per - hi) @(negedge clk_i);
      end
   endtask

   // Scoreboard: every valid strobe must match the oldest expectation of its channel.
   logic        mon_v;
   logic [63:0] mon_p, mon_h;
   exp_t        mon_e;
   always @(negedge clk_i) begin
      for (int c = 0; c < 4; c++) begin
         if (c < 3) begin
            mon_v = if_a.valid_o[c];
            mon_p = 64'(if_a.period_o[c]);
            mon_h = 64'(if_a.high_o[c]);
         end else begin
            mon_v = if_b.valid_o[0];
            mon_p = 64'(if_b.period_o[0]);
            mon_h = 64'(if_b.high_o[0]);
         end
         if (mon_v === 1'b1) begin
            if (exp_q[c].size() == 0) begin
               check($sformatf("ch%0d_unexpected_valid", c), 64'd1, 64'd0);
            end else begin
               mon_e = exp_q[c].pop_front();
               check($sformatf("ch%0d_period", c), mon_p, 64'(mon_e.period));
               check($sformatf("ch%0d_high", c), mon_h, 64'(mon_e.high));
               last_p[c] = mon_e.period;
               last_h[c] = mon_e.high;
            end
         end
      end
   end

   initial begin
      rstn_i = 1'b0;
      pwm_a = '0;
      pwm_b = '0;
      if_a.enable_i = '0;
      if_a.prescaler_i = '0;
      if_a.clear_i = '0;
      if_b.enable_i = '0;
      if_b.prescaler_i = '0;
      if_b.clear_i = '0;
      for (int c = 0; c < 4; c++) begin
         last_p[c] = 0;
         last_h[c] = 0;
      end

      // Reset with inputs toggling
      repeat (2) begin
         @(negedge clk_i);
         pwm_a = ~pwm_a;
         pwm_b = ~pwm_b;
         if_a.enable_i = ~if_a.enable_i;
         if_b.enable_i = ~if_b.enable_i;
         if_a.clear_i = ~if_a.clear_i;
      end
      @(negedge clk_i);
      pwm_a = '0;
      pwm_b = '0;
      if_a.enable_i = '0;
      if_b.enable_i = '0;
      if_a.clear_i = '0;
      for (int c = 0; c < 3; c++) begin
         check($sformatf("rst_a_period%0d", c), 64'(if_a.period_o[c]), 64'd0);
         check($sformatf("rst_a_high%0d", c), 64'(if_a.high_o[c]), 64'd0);
      end
      check("rst_a_valid", 64'(if_a.valid_o), 64'd0);
      check("rst_a_ovf", 64'(if_a.overflow_o), 64'd0);
      check("rst_b_period", 64'(if_b.period_o[0]), 64'd0);
      check("rst_b_high", 64'(if_b.high_o[0]), 64'd0);
      check("rst_b_flags", 64'({if_b.valid_o, if_b.overflow_o}), 64'd0);
      rstn_i = 1'b1;
      repeat (4) @(negedge clk_i);

      // Concurrent channels with different prescalers
      if_a.prescaler_i[0] = 32'd0;
      if_a.prescaler_i[1] = 32'd1;
      if_a.prescaler_i[2] = 32'd2;
      if_a.enable_i = 3'b111;
      repeat (4) @(negedge clk_i);
      fork
         drive_wave(0, 4, 10, 7, 0);
         drive_wave(1, 3, 10, 4, 1);
         drive_wave(2, 3, 12, 5, 2);
      join
      repeat (10) @(negedge clk_i);
      for (int c = 0; c < 3; c++)
         check($sformatf("ch%0d_pending", c), 64'(exp_q[c].size()), 64'd0);

      // Abort mid-LOW on channel 0, then re-arm
      if_a.enable_i[0] = 1'b0;
      repeat (2) @(negedge clk_i);
      if_a.enable_i[0] = 1'b1;
      repeat (3) @(negedge clk_i);
      set_pin(0, 1'b1);
      repeat (9) @(negedge clk_i);
      set_pin(0, 1'b0);
      repeat (2) @(negedge clk_i);
      if_a.enable_i[0] = 1'b0;
      repeat (3) @(negedge clk_i);
      if_a.enable_i[0] = 1'b1;
      repeat (3) @(negedge clk_i);
      check("abort_hold_period", 64'(if_a.period_o[0]), 64'(last_p[0]));
      check("abort_hold_high", 64'(if_a.high_o[0]), 64'(last_h[0]));
      drive_wave(0, 1, 14, 9, 0);
      repeat (6) @(negedge clk_i);
      check("ch0_abort_pending", 64'(exp_q[0].size()), 64'd0);
      check("ch0_after_abort_period", 64'(if_a.period_o[0]), 64'd14);
      if_a.enable_i = '0;

      // Saturation on the 8-bit instance
      if_b.prescaler_i[0] = 8'd0;
      if_b.enable_i = 1'b1;
      repeat (4) @(negedge clk_i);
      set_pin(3, 1'b1);
      repeat (257) @(posedge clk_i);
      #1 check("ovf_before_sat", 64'(if_b.overflow_o[0]), 64'd0);
      @(posedge clk_i);
      #1 check("ovf_at_sat", 64'(if_b.overflow_o[0]), 64'd1);
      repeat (42) @(negedge clk_i);
      check("ovf_sticky", 64'(if_b.overflow_o[0]), 64'd1);
      set_pin(3, 1'b0);
      repeat (5) @(negedge clk_i);

      // Second saturation with clear_i in the same cycle, then clear alone
      set_pin(3, 1'b1);
      repeat (257) @(posedge clk_i);
      #1 check("ovf_still_set", 64'(if_b.overflow_o[0]), 64'd1);
      if_b.clear_i = 1'b1;
      @(posedge clk_i);
      #1 check("ovf_set_wins", 64'(if_b.overflow_o[0]), 64'd1);
      @(posedge clk_i);
      #1 check("ovf_cleared", 64'(if_b.overflow_o[0]), 64'd0);
      if_b.clear_i = 1'b0;
      @(negedge clk_i);
      set_pin(3, 1'b0);
      repeat (5) @(negedge clk_i);
      drive_wave(3, 3, 10, 7, 0);
      repeat (10) @(negedge clk_i);
      check("ch3_pending", 64'(exp_q[3].size()), 64'd0);
      check("ovf_after_clean", 64'(if_b.overflow_o[0]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Multi-channel PWM input capture block, the receive-side counterpart of the GPIO PWM generator. Per channel it synchronizes an external PWM pin, measures the period (rising edge to rising edge) and the high time (rising edge to falling edge) in prescaled clock ticks, and publishes both as a coherent pair with a one-cycle valid strobe. It sits in the GPIO peripheral beside the generator, with its configuration and results mapped into the same APB register bank.

Parameters:
CHANNELS, 3, number of independent capture channels
CNT_W, 32, width of the prescaler, period and high-time counters
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (minimum 2)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, synchronous, active-low
pwm_i  in  CHANNELS  asynchronous PWM inputs
enable_i  in  CHANNELS  per-channel capture enable
prescaler_i  in  CHANNELS x CNT_W  tick divider; one tick every prescaler_i+1 clocks
clear_i  in  CHANNELS  clears the sticky overflow flag
period_o  out  CHANNELS x CNT_W  last measured period, in ticks
high_o  out  CHANNELS x CNT_W  last measured high time, in ticks
valid_o  out  CHANNELS  one-cycle strobe when period_o/high_o update
overflow_o  out  CHANNELS  sticky flag: a measurement was discarded on saturation

Behaviour:
- Reset: synchronous, active-low (rstn_i low at a clk_i edge). All of the following clear to 0: outputs, synchronizers, edge register, counters. Every FSM enters IDLE.
- Input path: pwm_i[i] passes through SYNC_STAGES flops to give s. The flop s_d holds the previous s. rise = s & ~s_d, fall = ~s & s_d.
- Latency: outputs update on the clock edge at which rise is true. This is SYNC_STAGES+1 clock edges after the first edge that samples the new pin level.
- Tick generation: the prescale counter pre resets to 0 on rise. Otherwise it wraps at prescaler_i; the tick occurs on the wrap. With prescaler_i = 0, every clock is a tick.
- Measurement counter cnt:
  - On rise: cnt <= 1.
  - Otherwise, on each tick in HIGH or LOW: cnt <= cnt+1.
  - A result equals 1+floor((P-1)/(prescaler_i+1)). This is exactly P/(prescaler_i+1) when P is a multiple of prescaler_i+1.
- FSM per channel:
  - IDLE: enable_i=0. cnt and pre are held at 0 and valid_o=0. period_o and high_o keep their last values. When enable_i goes to 1, go to ARM.
  - ARM: wait for the first rise, then go to HIGH with cnt<=1. No valid strobe on this first edge.
  - HIGH: on fall, capture hi_tmp <= cnt (value before update), then go to LOW.
  - LOW: on rise, set period_o <= cnt, high_o <= hi_tmp and valid_o <= 1 (for one cycle). Restart with cnt<=1 and go to HIGH.
  - A rise seen while in HIGH is impossible (a fall must come first), so no extra handling is needed.
- Saturation: in HIGH or LOW, if cnt is all-ones and a tick occurs without rise or fall:
  - set overflow_o;
  - go to ARM;
  - publish nothing.
- Edge and saturation in the same cycle: the edge wins. The measurement is processed normally with the saturated value, and overflow_o is not set.
- Deassertion of enable_i in any state: go to IDLE on the next clock and discard any partial measurement.
- overflow_o: sticky. clear_i clears it. If set and clear occur in the same cycle, set wins.
- prescaler_i must be held stable while enabled. A change takes effect at the next pre wrap.
- Channels are fully independent. Every output is registered.

Decomposition:
- Package pwm_capture_pkg holds:
  - the state enum (IDLE, ARM, HIGH, LOW);
  - the default CNT_W constant;
  - the count type typedef.
- Sub-module pwm_capture_chan contains one synchronizer, prescaler, counter and FSM. The top level instantiates it CHANNELS times in a generate loop.

Test Plan:
- Reset: drive rstn_i low for 2 clocks with inputs toggling -> all outputs 0 and no valid_o.
- Loopback from the generator (period reg 9, duty 3, i.e. 10-clock period, low 3 / high 7), prescaler_i=0 -> first rise only arms; then valid_o pulses every 10 clocks with period_o=10, high_o=7.
- prescaler_i=1 with a 10-clock period and 4 clocks high -> period_o=5, high_o=2.
- CNT_W=8 instance with prescaler 0: one rise, then hold high for 300 clocks -> overflow_o=1 within 256 clocks of the rise and no valid_o. Then a clean 10/7 waveform -> valid_o resumes after the re-arm edge.
- Drop enable_i mid-LOW, then re-enable -> no valid_o for the aborted period, period_o/high_o hold their old values, and the first valid_o comes one full period after the re-arm rise.
- overflow_o=1 with clear_i asserted in the same cycle as a new saturation -> overflow_o stays 1. clear_i alone on the next cycle -> overflow_o becomes 0.
